// File: rtl/hand_cmd_tx.sv
// hand_cmd_tx: Avalon-MM programmable finger-position command transmitter.
// Each pending finger n emits the 5-byte ASCII frame "F<n> <pos>\n" over an
// 8N1 UART line, lowest finger first, with a runtime-programmable bit divisor.
module hand_cmd_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUDRATE    = 115200
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  input  logic [15:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest
);

  localparam int unsigned DIV_RST     = CLK_FREQ_HZ / BAUDRATE;
  localparam int unsigned NUM_FINGERS = 5;
  localparam int unsigned LAST_BYTE   = 4;
  localparam int unsigned LAST_BIT    = 7;

  typedef enum logic [1:0] {IDLE, SELECT, BYTE, WAIT} frame_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  logic [7:0]  reg_sel;
  logic [4:0]  pending, pending_nxt, wr_mask, sel_clear;
  logic [15:0] pos [NUM_FINGERS];
  logic [15:0] div_reg, div_eff;
  logic        rd_ack;
  logic [31:0] rd_value;
  logic        unused_bits;

  frame_state_t frame_state, frame_nxt;
  logic [2:0]   byte_idx, byte_idx_nxt, finger, finger_nxt, low_idx;
  logic [7:0]   snap, snap_nxt, tx_byte;
  logic         tx_start, tx_done;

  ser_state_t  ser_state, ser_nxt;
  logic [15:0] bit_cnt, cnt_nxt, div_lat, div_lat_nxt;
  logic [7:0]  shreg, sh_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic        line_nxt, bit_last;

  assign reg_sel     = address[15:8];
  assign unused_bits = ^{address[7:0], writedata[31:16]};
  assign waitrequest = read && !rd_ack && !i_Reset;
  assign wr_mask     = (write && reg_sel == 8'h00) ? writedata[4:0] : 5'b0;
  // A same-cycle CTRL write wins over the SELECT clear of that bit.
  assign pending_nxt = (pending & ~sel_clear) | wr_mask;
  assign div_eff     = (div_reg < 16'd2) ? 16'd2 : div_reg;

  // Read-data mux for the register map.
  always_comb begin
    rd_value = 32'hDEADBEEF;
    case (reg_sel)
      8'h00:   rd_value = {26'b0, o_Tx_Active, pending};
      8'h01:   rd_value = {16'b0, pos[0]};
      8'h02:   rd_value = {16'b0, pos[1]};
      8'h03:   rd_value = {16'b0, pos[2]};
      8'h04:   rd_value = {16'b0, pos[3]};
      8'h05:   rd_value = {16'b0, pos[4]};
      8'h06:   rd_value = {16'b0, div_reg};
      default: rd_value = 32'hDEADBEEF;
    endcase
  end

  // Register file, pending mask and one-wait-state read handshake.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pending  <= '0;
      for (int i = 0; i < NUM_FINGERS; i++) pos[i] <= '0;
      div_reg  <= 16'(DIV_RST);
      readdata <= '0;
      rd_ack   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (write) begin
        case (reg_sel)
          8'h01:   pos[0]  <= writedata[15:0];
          8'h02:   pos[1]  <= writedata[15:0];
          8'h03:   pos[2]  <= writedata[15:0];
          8'h04:   pos[3]  <= writedata[15:0];
          8'h05:   pos[4]  <= writedata[15:0];
          8'h06:   div_reg <= writedata[15:0];
          default: ;
        endcase
      end
      if (read && !rd_ack) begin
        readdata <= rd_value;
        rd_ack   <= 1'b1;
      end else begin
        rd_ack   <= 1'b0;
      end
    end
  end

  // Lowest pending finger, as a 0-based index.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_FINGERS - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = 3'(i);
    end
  end

  // Current frame byte.
  always_comb begin
    case (byte_idx)
      3'd0:    tx_byte = 8'h46;
      3'd1:    tx_byte = 8'h30 + 8'(finger);
      3'd2:    tx_byte = 8'h20;
      3'd3:    tx_byte = snap;
      default: tx_byte = 8'h0A;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      frame_state <= IDLE;
      byte_idx    <= '0;
      finger      <= '0;
      snap        <= '0;
    end else begin
      frame_state <= frame_nxt;
      byte_idx    <= byte_idx_nxt;
      finger      <= finger_nxt;
      snap        <= snap_nxt;
    end
  end

  // Frame FSM next state: pick finger, step through its five bytes.
  always_comb begin
    frame_nxt    = frame_state;
    byte_idx_nxt = byte_idx;
    finger_nxt   = finger;
    snap_nxt     = snap;
    sel_clear    = '0;
    tx_start     = 1'b0;
    case (frame_state)
      IDLE: if (pending != '0) frame_nxt = SELECT;
      SELECT: begin
        sel_clear    = 5'b00001 << low_idx;
        finger_nxt   = low_idx + 3'd1;
        snap_nxt     = pos[low_idx][7:0];
        byte_idx_nxt = '0;
        frame_nxt    = BYTE;
      end
      BYTE: begin
        tx_start  = 1'b1;
        frame_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (byte_idx == 3'(LAST_BYTE)) begin
            frame_nxt = (pending != '0) ? SELECT : IDLE;
          end else begin
            byte_idx_nxt = byte_idx + 3'd1;
            frame_nxt    = BYTE;
          end
        end
      end
      default: frame_nxt = IDLE;
    endcase
  end

  assign bit_last = (bit_cnt == div_lat - 16'd1);
  assign tx_done  = (ser_state == S_STOP) && bit_last;

  // Serializer state register plus registered line and activity flag.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      ser_state   <= S_IDLE;
      bit_cnt     <= '0;
      div_lat     <= 16'd2;
      shreg       <= '0;
      bit_idx     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
    end else begin
      ser_state   <= ser_nxt;
      bit_cnt     <= cnt_nxt;
      div_lat     <= div_lat_nxt;
      shreg       <= sh_nxt;
      bit_idx     <= idx_nxt;
      o_Tx_Serial <= line_nxt;
      o_Tx_Active <= (pending_nxt != '0) || (frame_nxt != IDLE) || (ser_nxt != S_IDLE);
    end
  end

  // Serializer next state: start, 8 data bits LSB first, stop; divisor latched per byte.
  always_comb begin
    ser_nxt     = ser_state;
    cnt_nxt     = bit_cnt;
    div_lat_nxt = div_lat;
    sh_nxt      = shreg;
    idx_nxt     = bit_idx;
    line_nxt    = o_Tx_Serial;
    case (ser_state)
      S_IDLE: begin
        line_nxt = 1'b1;
        if (tx_start) begin
          ser_nxt     = S_START;
          line_nxt    = 1'b0;
          sh_nxt      = tx_byte;
          cnt_nxt     = '0;
          div_lat_nxt = div_eff;
        end
      end
      S_START: begin
        cnt_nxt = bit_cnt + 16'd1;
        if (bit_last) begin
          cnt_nxt  = '0;
          ser_nxt  = S_DATA;
          idx_nxt  = '0;
          line_nxt = shreg[0];
        end
      end
      S_DATA: begin
        cnt_nxt = bit_cnt + 16'd1;
        if (bit_last) begin
          cnt_nxt = '0;
          if (bit_idx == 3'(LAST_BIT)) begin
            ser_nxt  = S_STOP;
            line_nxt = 1'b1;
          end else begin
            sh_nxt   = shreg >> 1;
            line_nxt = shreg[1];
            idx_nxt  = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        cnt_nxt = bit_cnt + 16'd1;
        if (bit_last) begin
          cnt_nxt  = '0;
          ser_nxt  = S_IDLE;
          line_nxt = 1'b1;
        end
      end
      default: ser_nxt = S_IDLE;
    endcase
  end

endmodule
